// File: rtl/blink_monitor_if.sv
// -----------------------------------------------------------------------------
// blink_monitor_if
//
// Bundles the monitored blink line, the fault-clear pulse and the status
// outputs of blink_monitor so the checker can be dropped next to a blinker
// with a single connection. clk and rst are kept as plain ports of the
// monitor itself.
//
// Parameters:
//   CBITS   blinker counter width; must match the blink_monitor instance
//
// Signals:
//   led      monitored blink line, synchronous to clk  (master -> slave)
//   clr      one-cycle pulse, clears a latched fault    (master -> slave)
//   edge_p   one-cycle pulse per detected led toggle    (slave -> master)
//   locked   blink verified in tolerance                (slave -> master)
//   fault    sticky, lock was lost                      (slave -> master)
//   period   last measured toggle interval, CBITS+1 b   (slave -> master)
//   err_cnt  saturating count of bad/timed-out intervals(slave -> master)
//
// Modports:
//   master  the side that owns the blink line and reads the status
//   slave   the monitor
// -----------------------------------------------------------------------------
interface blink_monitor_if #(
  parameter int CBITS = 14
);
  logic             led;
  logic             clr;
  logic             edge_p;
  logic             locked;
  logic             fault;
  logic [CBITS:0]   period;
  logic [7:0]       err_cnt;

  modport master (
    output led,
    output clr,
    input  edge_p,
    input  locked,
    input  fault,
    input  period,
    input  err_cnt
  );

  modport slave (
    input  led,
    input  clr,
    output edge_p,
    output locked,
    output fault,
    output period,
    output err_cnt
  );
endinterface : blink_monitor_if

// File: rtl/blink_monitor.sv
// -----------------------------------------------------------------------------
// blink_monitor
//
// Receive-side checker for an LED blinker. It samples the free-running led
// line, detects every toggle, measures the number of clk cycles between
// consecutive toggles and compares that interval with the expected half
// period EXP = 2**CBITS (accepted window EXP-TOL .. EXP+TOL).
//
// After LOCK_N consecutive good intervals the monitor reports `locked`.
// A bad interval or a silent line (no toggle for EXP+TOL+1 cycles) while
// locked latches `fault` until `clr` is pulsed. Every bad or timed-out
// interval seen while acquiring or locked bumps a saturating error counter.
//
// Parameters:
//   CBITS   blinker counter width, EXP = 2**CBITS
//   TOL     accepted deviation in cycles, TOL < EXP
//   LOCK_N  consecutive good intervals needed for lock, 1..15
//
// Ports:
//   clk     clock
//   rst     synchronous active-high reset, overrides clr
//   mon     blink_monitor_if.slave:
//             led, clr in; edge_p, locked, fault, period, err_cnt out
//
// State machine:
//   IDLE    wait for a first toggle, no timeout
//   ACQ     count good intervals towards lock; timeout drops back to IDLE
//   LOCKED  blink verified; any bad interval or timeout -> FAULT
//   FAULT   sticky until clr; period and edge_p keep tracking the line
// -----------------------------------------------------------------------------
module blink_monitor #(
  parameter int CBITS  = 14,
  parameter int TOL    = 2,
  parameter int LOCK_N = 3
) (
  input  logic             clk,
  input  logic             rst,
  blink_monitor_if.slave   mon
);

  // ---------------------------------------------------------------------------
  // Derived constants, all sized to the interval counter width.
  // ---------------------------------------------------------------------------
  localparam int CW  = CBITS + 1;
  localparam int EXP = 2 ** CBITS;

  localparam logic [CW-1:0] INT_LO  = CW'(EXP - TOL);
  localparam logic [CW-1:0] INT_HI  = CW'(EXP + TOL);
  // First count at which a silent line is declared dead.
  localparam logic [CW-1:0] TMO_CNT = CW'(EXP + TOL + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0]    LOCK_CNT = 4'(LOCK_N);
  localparam logic [7:0]    ERR_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values.
  // ---------------------------------------------------------------------------
  state_e          state_q,   state_d;
  logic            led_q;
  logic            edge_p_q,  edge_p_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [3:0]      good_q,    good_d;
  logic [CW-1:0]   period_q,  period_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  // Combinational helpers.
  logic            toggle;
  logic            interval_ok;
  logic            timeout;
  logic            err_inc;
  logic [3:0]      good_inc;

  // ---------------------------------------------------------------------------
  // Edge detect and interval classification.
  //
  // cnt_q holds the number of cycles since the previous toggle, so at a
  // toggle it is exactly the interval just completed. A toggle always
  // wins over the timeout because it restarts the count in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    toggle      = mon.led ^ led_q;
    interval_ok = (cnt_q >= INT_LO) && (cnt_q <= INT_HI);
    timeout     = !toggle && (cnt_q == TMO_CNT);
    good_inc    = good_q + 4'd1;
  end

  // ---------------------------------------------------------------------------
  // Interval counter: restart at 1 on a toggle, otherwise count up and stick
  // at all-ones so a long-dead line cannot wrap back into the good window.
  // ---------------------------------------------------------------------------
  always_comb begin
    edge_p_d = toggle;
    if (toggle) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock state machine.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default before the case
    // statement; a path that leaves one unassigned would infer a latch.
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    err_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (toggle) begin
          state_d = ACQ;
          good_d  = 4'd0;
        end
      end

      ACQ: begin
        if (toggle) begin
          period_d = cnt_q;
          if (interval_ok) begin
            good_d = good_inc;
            if (good_inc == LOCK_CNT) begin
              state_d = LOCKED;
            end
          end else begin
            good_d  = 4'd0;
            err_inc = 1'b1;
          end
        end else if (timeout) begin
          // The line went quiet before lock: start acquisition over.
          good_d  = 4'd0;
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end

      LOCKED: begin
        if (toggle) begin
          period_d = cnt_q;
          if (!interval_ok) begin
            err_inc = 1'b1;
            state_d = FAULT;
          end
        end else if (timeout) begin
          err_inc = 1'b1;
          state_d = FAULT;
        end
      end

      FAULT: begin
        // The fault stays latched, but the line is still measured so the
        // status display shows what the blinker is actually doing.
        if (toggle) begin
          period_d = cnt_q;
        end
        if (mon.clr) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Error counter saturates so a long-running bad blinker stays visible.
  always_comb begin
    if (err_inc && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  //
  // led_q reloads the live line value during reset so that releasing reset
  // never produces a spurious toggle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this clock edge.
    if (rst) begin
      state_q   <= IDLE;
      led_q     <= mon.led;
      edge_p_q  <= 1'b0;
      cnt_q     <= '0;
      good_q    <= 4'd0;
      period_q  <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      led_q     <= mon.led;
      edge_p_q  <= edge_p_d;
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      period_q  <= period_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. locked and fault decode the registered state, so they can never
  // be high together and carry no combinational path from the inputs.
  // ---------------------------------------------------------------------------
  assign mon.edge_p  = edge_p_q;
  assign mon.locked  = (state_q == LOCKED);
  assign mon.fault   = (state_q == FAULT);
  assign mon.period  = period_q;
  assign mon.err_cnt = err_cnt_q;

endmodule : blink_monitor

// File: tb/tb_blink_monitor.sv
// -----------------------------------------------------------------------------
// tb_blink_monitor
//
// Self-checking bench for blink_monitor with CBITS=4 (EXP=16), TOL=1,
// LOCK_N=3. Each toggle of led pushes the expected edge_p cycle and the
// expected period onto a scoreboard; a negedge monitor pops and compares
// whenever edge_p is seen, and flags edges that are missing or unexpected.
// Scenario tasks check locked/fault/err_cnt/period inline.
// -----------------------------------------------------------------------------
module tb_blink_monitor;

  localparam int CBITS  = 4;
  localparam int TOL    = 1;
  localparam int LOCK_N = 3;
  localparam int CW     = CBITS + 1;
  localparam int CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  blink_monitor_if #(.CBITS(CBITS)) bus ();

  blink_monitor #(
    .CBITS  (CBITS),
    .TOL    (TOL),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  typedef struct {
    int              due;
    logic [CW-1:0]   period;
  } exp_t;

  exp_t           sb[$];
  int             errors = 0;
  int             checks = 0;
  int             mcyc   = 0;
  int             since  = 0;
  logic [CW-1:0]  model_period = '0;

  // ---------------------------------------------------------------------------
  // Scoreboard monitor, sampling on the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    exp_t e;
    mcyc++;
    if (bus.edge_p === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL edge_p_unexpected cyc=%0d got edge_p=1 want 0", mcyc);
      end else begin
        e = sb.pop_front();
        if (e.due !== mcyc) begin
          errors++;
          $display("FAIL edge_p_timing got cyc=%0d want cyc=%0d", mcyc, e.due);
        end
        checks++;
        if (bus.period !== e.period) begin
          errors++;
          $display("FAIL period got=%0d want=%0d (cyc=%0d)", bus.period, e.period, mcyc);
        end
      end
    end else if (sb.size() > 0 && sb[0].due < mcyc) begin
      checks++;
      errors++;
      $display("FAIL edge_p_missing got no pulse want pulse at cyc=%0d", sb[0].due);
      e = sb.pop_front();
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus primitives.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      since++;
    end
  endtask

  // Toggle led. upd says whether the monitor is in a state that records the
  // interval; the expected period is the cycle count since the last toggle,
  // saturating at the counter maximum.
  task automatic toggle(input bit upd);
    bus.led = ~bus.led;
    if (upd) model_period = (since > CMAX) ? CW'(CMAX) : CW'(since);
    sb.push_back('{due: mcyc + 2, period: model_period});
    since = 0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.clr = 1'b0;
    tick(2);
    rst          = 1'b0;
    model_period = '0;
  endtask

  // Reset, then four 16-cycle toggles; ends one cycle after the locking edge.
  task automatic lock_up(input string tag);
    do_reset();
    toggle(1'b0);
    repeat (LOCK_N) begin
      tick(16);
      toggle(1'b1);
    end
    tick(1);
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL %s.lock_up.locked got=%0b want=1", tag, bus.locked);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios.
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bit saw_edge;
    bus.led = 1'b0;
    bus.clr = 1'b0;
    do_reset();
    checks++;
    if (bus.edge_p !== 1'b0) begin errors++; $display("FAIL reset.edge_p got=%0b want=0", bus.edge_p); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset.locked got=%0b want=0", bus.locked); end
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset.fault got=%0b want=0", bus.fault); end
    checks++;
    if (bus.period !== '0) begin errors++; $display("FAIL reset.period got=%0d want=0", bus.period); end
    checks++;
    if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset.err_cnt got=%0d want=0", bus.err_cnt); end

    saw_edge = 1'b0;
    repeat (40) begin
      tick(1);
      if (bus.edge_p !== 1'b0) saw_edge = 1'b1;
    end
    checks++;
    if (saw_edge !== 1'b0) begin errors++; $display("FAIL idle_hold.edge_p got=1 want=0"); end
    checks++;
    if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL idle_hold.err_cnt got=%0d want=0", bus.err_cnt); end
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL idle_hold.locked got=%0b want=0", bus.locked); end
  endtask

  task automatic test_lock_nominal();
    do_reset();
    toggle(1'b0);
    tick(16); toggle(1'b1);
    tick(16); toggle(1'b1);
    tick(16); toggle(1'b1);
    // Fourth toggle driven but not yet sampled: still acquiring.
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL nominal.locked_early got=%0b want=0", bus.locked); end
    tick(1);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL nominal.locked got=%0b want=1", bus.locked); end
    checks++;
    if (bus.period !== CW'(16)) begin errors++; $display("FAIL nominal.period got=%0d want=16", bus.period); end

    // clr outside FAULT does nothing.
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    checks++;
    if (bus.locked !== 1'b1 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL nominal.clr_no_effect got locked=%0b fault=%0b want locked=1 fault=0", bus.locked, bus.fault);
    end
    tick(14); toggle(1'b1);
    tick(2);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nominal.stay_locked got locked=%0b err=%0d want locked=1 err=0", bus.locked, bus.err_cnt);
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    toggle(1'b0);
    tick(15); toggle(1'b1);
    tick(17); toggle(1'b1);
    tick(16); toggle(1'b1);
    tick(1);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL bounds.locked got=%0b want=1", bus.locked); end
    checks++;
    if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL bounds.err_cnt got=%0d want=0", bus.err_cnt); end

    // Interval 18 in ACQ is a bad edge, not a timeout.
    do_reset();
    toggle(1'b0);
    tick(16); toggle(1'b1);
    tick(18); toggle(1'b1);
    tick(1);
    checks++;
    if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL bad18.err_cnt got=%0d want=1", bus.err_cnt); end
    checks++;
    if (bus.fault !== 1'b0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL bad18.state got locked=%0b fault=%0b want 0 0", bus.locked, bus.fault);
    end
    // Good count restarted: two good intervals must not lock.
    tick(15); toggle(1'b1);
    tick(16); toggle(1'b1);
    tick(1);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL bad18.good_reset got locked=%0b want=0", bus.locked); end
    tick(15); toggle(1'b1);
    tick(1);
    checks++;
    if (bus.locked !== 1'b1) begin errors++; $display("FAIL bad18.relock got=%0b want=1", bus.locked); end
  endtask

  task automatic test_timeout_locked();
    lock_up("timeout");
    tick(17);
    checks++;
    if (bus.fault !== 1'b0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout.early got locked=%0b fault=%0b want locked=1 fault=0", bus.locked, bus.fault);
    end
    tick(1);
    checks++;
    if (bus.fault !== 1'b1 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout.fire got locked=%0b fault=%0b want locked=0 fault=1", bus.locked, bus.fault);
    end
    checks++;
    if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL timeout.err_cnt got=%0d want=1", bus.err_cnt); end
    tick(10);
    checks++;
    if (bus.fault !== 1'b1 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL timeout.sticky got fault=%0b err=%0d want fault=1 err=1", bus.fault, bus.err_cnt);
    end
    // Edges in FAULT still refresh period (checked by the scoreboard).
    toggle(1'b1);
    tick(2);
    checks++;
    if (bus.fault !== 1'b1) begin errors++; $display("FAIL fault_edge.fault got=%0b want=1", bus.fault); end
  endtask

  task automatic test_clr_with_rst();
    lock_up("clr_rst");
    tick(18);
    checks++;
    if (bus.fault !== 1'b1) begin errors++; $display("FAIL clr_rst.pre_fault got=%0b want=1", bus.fault); end
    bus.clr = 1'b1;
    rst     = 1'b1;
    tick(1);
    rst     = 1'b0;
    bus.clr = 1'b0;
    model_period = '0;
    checks++;
    if (bus.fault !== 1'b0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL clr_rst.state got locked=%0b fault=%0b want 0 0", bus.locked, bus.fault);
    end
    checks++;
    if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL clr_rst.err_cnt got=%0d want=0", bus.err_cnt); end
    checks++;
    if (bus.period !== '0) begin errors++; $display("FAIL clr_rst.period got=%0d want=0", bus.period); end
  endtask

  task automatic test_clr();
    lock_up("clr");
    tick(18);
    checks++;
    if (bus.fault !== 1'b1 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr.pre got fault=%0b err=%0d want fault=1 err=1", bus.fault, bus.err_cnt);
    end
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    checks++;
    if (bus.fault !== 1'b0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL clr.state got locked=%0b fault=%0b want 0 0", bus.locked, bus.fault);
    end
    checks++;
    if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL clr.err_kept got=%0d want=1", bus.err_cnt); end
    tick(5);
    checks++;
    if (bus.fault !== 1'b0 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr.idle got fault=%0b err=%0d want fault=0 err=1", bus.fault, bus.err_cnt);
    end
    toggle(1'b0);
    tick(16); toggle(1'b1);
    tick(16); toggle(1'b1);
    tick(16); toggle(1'b1);
    checks++;
    if (bus.locked !== 1'b0) begin errors++; $display("FAIL clr.relock_early got=%0b want=0", bus.locked); end
    tick(1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr.relock got locked=%0b err=%0d want locked=1 err=1", bus.locked, bus.err_cnt);
    end
  endtask

  task automatic test_saturate();
    bit ever_locked;
    do_reset();
    ever_locked = 1'b0;
    toggle(1'b0);
    for (int i = 1; i <= 300; i++) begin
      tick(5);
      toggle(1'b1);
      if (bus.locked !== 1'b0) ever_locked = 1'b1;
      if (i == 255) begin
        // Interval 255 driven but not yet sampled: 254 bad intervals counted.
        checks++;
        if (bus.err_cnt !== 8'd254) begin errors++; $display("FAIL sat.err_254 got=%0d want=254", bus.err_cnt); end
      end
    end
    tick(2);
    checks++;
    if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL sat.err_cnt got=%0d want=255", bus.err_cnt); end
    checks++;
    if (ever_locked !== 1'b0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL sat.never_locked got locked seen=%0b want 0", ever_locked);
    end
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL sat.fault got=%0b want=0", bus.fault); end
  endtask

  initial begin
    bus.led = 1'b0;
    bus.clr = 1'b0;
    test_reset();
    test_lock_nominal();
    test_boundaries();
    test_timeout_locked();
    test_clr_with_rst();
    test_clr();
    test_saturate();
    tick(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_blink_monitor
